// File: rtl/mult_pkg.sv
// Shared defaults and helpers for the handshaked pipelined multiplier.
// LAT is the unstalled accept-to-output latency in clock edges.
package mult_pkg;

    localparam int DEF_WIDTHA      = 16;
    localparam int DEF_WIDTHB      = 24;
    localparam int DEF_PIPE_STAGES = 4;
    localparam int DEF_TAG_W       = 4;
    localparam int LAT             = DEF_PIPE_STAGES + 1;

    // Extension bit above an operand's msb: its sign when signed, else zero.
    function automatic logic ext_bit(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One elastic pipeline stage: valid bit, data register and local ready term.
// A stage loads whenever it is empty or its downstream neighbour can take its contents.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_rdy,
    output logic          rdy,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    assign rdy   = !valid_r || dn_rdy;
    assign valid = valid_r;
    assign data  = data_r;

    // Stage state: flush drops the valid bit only; data is don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (rdy) begin
            valid_r <= up_valid;
            data_r  <= up_data;
        end
    end

endmodule

// File: rtl/mult_pipe_hs.sv
// Pipelined WIDTHA x WIDTHB multiplier with valid/ready handshake, per-operation signedness,
// tag pass-through, bubble collapsing and synchronous flush.
module mult_pipe_hs
    import mult_pkg::*;
#(
    parameter int WIDTHA      = DEF_WIDTHA,
    parameter int WIDTHB      = DEF_WIDTHB,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTHA-1:0]        a,
    input  logic [WIDTHB-1:0]        b,
    input  logic                     a_signed,
    input  logic                     b_signed,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTHA+WIDTHB-1:0] res,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    localparam int RW  = WIDTHA + WIDTHB;
    localparam int S0W = WIDTHA + WIDTHB + 2 + TAG_W;
    localparam int SNW = RW + TAG_W;

    logic [PIPE_STAGES:0] v_vec_s;
    logic                 s0_rdy_s;
    logic                 s0_v_s;
    logic [S0W-1:0]       s0_data_s;
    logic [WIDTHA-1:0]    s0_a_s;
    logic [WIDTHB-1:0]    s0_b_s;
    logic                 s0_as_s;
    logic                 s0_bs_s;
    logic [TAG_W-1:0]     s0_tag_s;
    logic [RW-1:0]        a_x_s;
    logic [RW-1:0]        b_x_s;
    logic [RW-1:0]        prod_s;

    mult_pipe_stage #(.DW(S0W)) u_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (in_valid),
        .up_data  ({a, b, a_signed, b_signed, in_tag}),
        .dn_rdy   (g_stage[1].rdy_s),
        .rdy      (s0_rdy_s),
        .valid    (s0_v_s),
        .data     (s0_data_s)
    );

    assign in_ready   = s0_rdy_s;
    assign v_vec_s[0] = s0_v_s;

    assign s0_a_s   = s0_data_s[S0W-1 -: WIDTHA];
    assign s0_b_s   = s0_data_s[TAG_W+2 +: WIDTHB];
    assign s0_as_s  = s0_data_s[TAG_W+1];
    assign s0_bs_s  = s0_data_s[TAG_W];
    assign s0_tag_s = s0_data_s[TAG_W-1:0];

    // Only the low RW bits of the (WIDTHA+1)x(WIDTHB+1) signed product are kept, so
    // sign-extending both operands to RW bits and multiplying modulo 2^RW is exact.
    assign a_x_s  = {{WIDTHB{ext_bit(s0_a_s[WIDTHA-1], s0_as_s)}}, s0_a_s};
    assign b_x_s  = {{WIDTHA{ext_bit(s0_b_s[WIDTHB-1], s0_bs_s)}}, s0_b_s};
    assign prod_s = a_x_s * b_x_s;

    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stage
        logic           rdy_s;
        logic           v_s;
        logic           up_v_s;
        logic           dn_rdy_s;
        logic [SNW-1:0] up_s;
        logic [SNW-1:0] d_s;

        if (k == 1) begin : g_first
            assign up_s   = {prod_s, s0_tag_s};
            assign up_v_s = s0_v_s;
        end else begin : g_mid
            assign up_s   = g_stage[k-1].d_s;
            assign up_v_s = g_stage[k-1].v_s;
        end

        if (k == PIPE_STAGES) begin : g_last
            assign dn_rdy_s = out_ready;
        end else begin : g_inner
            assign dn_rdy_s = g_stage[k+1].rdy_s;
        end

        mult_pipe_stage #(.DW(SNW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_v_s),
            .up_data  (up_s),
            .dn_rdy   (dn_rdy_s),
            .rdy      (rdy_s),
            .valid    (v_s),
            .data     (d_s)
        );

        assign v_vec_s[k] = v_s;
    end

    assign out_valid = g_stage[PIPE_STAGES].v_s;
    assign res       = g_stage[PIPE_STAGES].d_s[SNW-1 -: RW];
    assign out_tag   = g_stage[PIPE_STAGES].d_s[TAG_W-1:0];
    assign busy      = |v_vec_s;

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Self-checking bench for mult_pipe_hs: scoreboard fed from accepted operations, checked by a
// negedge monitor against an arithmetic reference model, plus directed latency/stall/flush/reset cases.
module tb_mult_pipe_hs;
    import mult_pkg::*;

    localparam int WA = 16;
    localparam int WB = 24;
    localparam int TW = 4;
    localparam int RW = WA + WB;

    typedef struct {
        logic [RW-1:0] res;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          a_signed;
    logic          b_signed;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] res;
    logic [TW-1:0] out_tag;
    logic          busy;

    exp_t q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   accepts = 0;
    bit   done;

    mult_pipe_hs #(.WIDTHA(WA), .WIDTHB(WB), .PIPE_STAGES(4), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret each operand per its sign flag, multiply as integers, keep RW bits.
    function automatic exp_t model(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                                   input logic as, input logic bs, input logic [TW-1:0] tg);
        longint sa;
        longint sb;
        longint p;
        exp_t   e;
        sa    = as ? longint'($signed(av)) : longint'(av);
        sb    = bs ? longint'($signed(bv)) : longint'(bv);
        p     = sa * sb;
        e.res = p[RW-1:0];
        e.tag = tg;
        return e;
    endfunction

    // Monitor: handshakes sampled at negedge commit at the following posedge.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("sb_res", 64'(res), 64'(q[0].res));
                    check("sb_tag", 64'(out_tag), 64'(q[0].tag));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, a_signed, b_signed, in_tag));
                accepts++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and returns just after the edge that accepted it.
    task automatic send(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                        input logic as, input logic bs, input logic [TW-1:0] tg);
        int n = 0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        a_signed = as;
        b_signed = bs;
        in_tag   = tg;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                break;
            end
            tick();
            n++;
            if (n >= 300) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TW-1:0] tg);
        logic [WA-1:0] av;
        logic [WB-1:0] bv;
        av = ($urandom_range(0, 7) == 0) ? 16'h8000 : WA'($urandom);
        bv = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : WB'($urandom);
        send(av, bv, 1'($urandom), 1'($urandom), tg);
    endtask

    // Called right after send() returns on an otherwise empty pipe with out_ready=1;
    // the accept edge itself counts as edge 1.
    task automatic expect_latency(input string name);
        int k = 1;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check(name, 64'(k), 64'(LAT));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        tick();
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        done      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Unsigned maximum operands and latency.
        out_ready = 1'b1;
        send(16'hFFFF, 24'hFFFFFF, 1'b0, 1'b0, 4'd3);
        expect_latency("t1_latency");
        check("t1_res", 64'(res), 64'hFF_FEFF_0001);
        check("t1_tag", 64'(out_tag), 64'd3);
        tick();

        // Signed corner cases.
        send(16'h8000, 24'h800000, 1'b1, 1'b1, 4'd1);
        expect_latency("t2a_latency");
        check("t2a_res", 64'(res), 64'h40_0000_0000);
        tick();
        send(16'hFFFF, 24'h000003, 1'b1, 1'b0, 4'd2);
        expect_latency("t2b_latency");
        check("t2b_res", 64'(res), 64'hFF_FFFF_FFFD);
        drain();

        // Backpressure: 8 ops against a stalled consumer.
        out_ready = 1'b0;
        base = accepts;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(TW'(i));
            end
        join_none
        repeat (10) tick();
        check("t3_accepts", 64'(accepts - base), 64'd5);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_tag_held", 64'(out_tag), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_no_gap", 64'(out_valid), 64'd1);
        end
        tick();
        drain();

        // Bubble collapsing with the output stalled.
        out_ready = 1'b0;
        base = accepts;
        check("t4_ready_0", 64'(in_ready), 64'd1);
        send_rand(4'd8);
        repeat (3) tick();
        check("t4_ready_1", 64'(in_ready), 64'd1);
        send_rand(4'd9);
        repeat (6) tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_ready_n", 64'(in_ready), 64'd1);
            send_rand(TW'(10 + i));
        end
        check("t4_full_ready", 64'(in_ready), 64'd0);
        check("t4_accepts", 64'(accepts - base), 64'd5);
        drain();

        // Flush with a simultaneous input that must be dropped.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_rand(TW'(i));
        flush    = 1'b1;
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 24'h000042;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_quiet", 64'(out_valid), 64'd0);
        end
        send(16'h0007, 24'h000006, 1'b0, 1'b0, 4'd5);
        expect_latency("t5_latency");
        check("t5_res", 64'(res), 64'd42);
        drain();

        // Asynchronous reset with operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(TW'(i + 1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_res", 64'(res), 64'd0);
        check("t6_out_tag", 64'(out_tag), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_no_stale", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_rand(TW'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
